shift_arbiter: RTL
==================

// Module: shift_arbiter
// PURPOSE
//  Shares one combinational WIDTH-bit rotator between NREQ requesters.
//  Round-robin arbitration; valid/ready on each request port and on the single response port.
//  Sits between the control units that need rotates and the rotator datapath.
//  Serialises requests and returns each result tagged with the requester id.
// PARAMETERS
//  WIDTH  4  data width in bits; power of two, >= 2
//  SHW    2  rotate-amount width; equals clog2(WIDTH)
//  NREQ   2  number of requesters, 2..8
//  IDW    1  requester-id width; equals clog2(NREQ), minimum 1
// PORTS
//  clk        in   1          single clock; all state updates on rising edge
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NREQ       request i pending
//  req_ready  out  NREQ       one-hot grant; request i accepted this cycle
//  req_data   in   NREQ*WIDTH operand; slice i = [i*WIDTH +: WIDTH]
//  req_shift  in   NREQ*SHW   rotate amount; slice i = [i*SHW +: SHW]
//  req_left   in   NREQ       1 = rotate left (toward MSB), 0 = rotate right
//  rsp_valid  out  1          result available
//  rsp_ready  in   1          consumer accepts result
//  rsp_data   out  WIDTH      rotated result
//  rsp_id     out  IDW        index of the requester that owns rsp_data
//  busy       out  1          1 whenever state != IDLE
// BEHAVIOUR
//  Reset values
//   - state = IDLE; rsp_valid = 0; rsp_data = 0; rsp_id = 0.
//   - req_ready = 0; last_grant = NREQ-1, so requester 0 wins first.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE
//   - If any req_valid bit is set, grant g = the first set index searching upward from
//     last_grant+1, with wrap-around.
//   - req_ready[g] = 1 combinationally in this cycle only.
//   - Capture data, shift, left and id = g; update last_grant = g; go to EXEC.
//   - If no req_valid bit is set, stay in IDLE with req_ready = 0.
//  EXEC
//   - rsp_data <= rot(operand); rsp_id <= captured id; go to RESP.
//  RESP
//   - rsp_valid = 1.
//   - rsp_data and rsp_id stay stable while rsp_ready = 0 (backpressure of any length).
//   - rsp_ready = 1 -> go to IDLE.
//   - No new grant is issued in the same cycle as the response handshake.
//  Timing
//   - Accept at cycle T -> rsp_valid high at T+2.
//   - Minimum 3 cycles per transaction.
//  Rotation rule
//   - Left by k:  out[j] = in[(j-k) mod WIDTH].
//   - Right by k: out[j] = in[(j+k) mod WIDTH].
//   - k = 0 passes the operand through unchanged in both directions.
//   - For WIDTH = 4, left by 3 equals right by 1, and left by 2 equals right by 2.
//  req_ready is 0 in the EXEC and RESP states.
//  Requesters hold valid/data until ready; a withdrawn request is simply never granted.
//  rst asserted in any state aborts the transaction, drops the captured operand and
//   emits no response; all outputs return to their reset values on the next edge.
//  No starvation: a continuously valid requester is granted within NREQ grants.
// STRUCTURE
//  Shared package shift_pkg
//   - State encoding constants: ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2.
//   - Direction constants: DIR_LEFT = 1'b1, DIR_RIGHT = 1'b0.
//  Sub-module rot_core
//   - Purely combinational rotator parameterised by WIDTH/SHW.
//   - Ports: din, amt, left, dout.
//  The arbiter, FSM and registers stay in shift_arbiter.
// TESTING
//  1. Reset: hold rst for 2 cycles with all req_valid = 1.
//     -> rsp_valid = 0, req_ready = 0, busy = 0, rsp_data = 0 during reset.
//  2. Single request: req0 data = 4'b1001, shift = 1, left = 1, rsp_ready = 1.
//     -> req_ready = 2'b01 at T; rsp_valid at T+2 with rsp_data = 4'b0011, rsp_id = 0.
//  3. Direction/amount sweep on 4'b1000, both directions, shifts 0..3.
//     -> left gives 1000, 0001, 0010, 0100; right gives 1000, 0100, 0010, 0001.
//  4. Contention: both requesters continuously valid.
//     -> grants alternate 0,1,0,1; each response carries the matching id.
//  5. Backpressure: rsp_ready = 0 for 5 cycles while rsp_valid = 1.
//     -> rsp_data and rsp_id unchanged; req_ready stays 0; busy stays 1.
//  6. Reset in EXEC (one cycle after grant).
//     -> no rsp_valid pulse follows; the next grant goes to requester 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants for the shift arbiter: FSM state encoding and rotate direction.
package shift_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_EXEC = ST_EXEC,
      S_RESP = ST_RESP
   } state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bus between the requesters, the response consumer and the arbiter.
interface shift_arbiter_if #(
   parameter int WIDTH = 4,
   parameter int SHW   = 2,
   parameter int NREQ  = 2,
   parameter int IDW   = 1
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ*SHW-1:0]   req_shift;
   logic [NREQ-1:0]       req_left;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WIDTH-1:0]      rsp_data;
   logic [IDW-1:0]        rsp_id;
   logic                  busy;

   // Requesters and response consumer side
   modport master (
      output req_valid, req_data, req_shift, req_left, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_data, req_shift, req_left, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/shift_arbiter_rot_core.sv
// Combinational WIDTH-bit rotator. WIDTH is a power of two, so SHW-bit index
// arithmetic wraps modulo WIDTH for free.
module rot_core
   import shift_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SHW   = 2
) (
   input  logic [WIDTH-1:0] din,
   input  logic [SHW-1:0]   amt,
   input  logic             left,
   output logic [WIDTH-1:0] dout
);

   // Left: out[j] = in[j-k]; right: out[j] = in[j+k], both mod WIDTH
   always_comb begin
      dout = '0;
      for (int j = 0; j < WIDTH; j++) begin
         if (left == DIR_LEFT) dout[j] = din[SHW'(j) - amt];
         else                  dout[j] = din[SHW'(j) + amt];
      end
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one rotator between NREQ requesters.
// One transaction at a time: IDLE (grant + capture) -> EXEC (rotate) -> RESP (hold).
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SHW   = 2,
   parameter int NREQ  = 2,
   parameter int IDW   = 1
) (
   input  logic            clk,
   input  logic            rst,
   shift_arbiter_if.slave  bus
);

   state_t           state;
   logic [IDW-1:0]   last_grant;
   logic [WIDTH-1:0] op_data;
   logic [SHW-1:0]   op_shift;
   logic             op_left;
   logic [IDW-1:0]   op_id;
   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic [IDW-1:0]   rsp_id_q;

   logic             grant_hit;
   logic [IDW-1:0]   grant_id;
   logic [WIDTH-1:0] rot_out;

   // Round-robin pick: first valid index searching upward from last_grant+1, wrapping
   always_comb begin
      int idx;
      logic [IDW-1:0] cand;
      grant_hit = 1'b0;
      grant_id  = last_grant;
      idx       = 0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = IDW'(idx);
         if (!grant_hit && bus.req_valid[cand]) begin
            grant_hit = 1'b1;
            grant_id  = cand;
         end
      end
   end

   // One-hot ready only while idle; suppressed during reset so nothing is accepted then
   always_comb begin
      bus.req_ready = '0;
      if (state == S_IDLE && !rst && grant_hit) bus.req_ready[grant_id] = 1'b1;
   end

   rot_core #(.WIDTH(WIDTH), .SHW(SHW)) u_rot (
      .din  (op_data),
      .amt  (op_shift),
      .left (op_left),
      .dout (rot_out)
   );

   // Transaction FSM with registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         last_grant  <= IDW'(NREQ - 1);
         op_data     <= '0;
         op_shift    <= '0;
         op_left     <= 1'b0;
         op_id       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_hit) begin
                  op_data    <= bus.req_data[grant_id*WIDTH +: WIDTH];
                  op_shift   <= bus.req_shift[grant_id*SHW +: SHW];
                  op_left    <= bus.req_left[grant_id];
                  op_id      <= grant_id;
                  last_grant <= grant_id;
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_data_q  <= rot_out;
               rsp_id_q    <= op_id;
               rsp_valid_q <= 1'b1;
               state       <= S_RESP;
            end
            S_RESP: begin
               // Back to idle on handshake; the next grant waits for the idle cycle
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.busy      = (state != S_IDLE);

endmodule
